io_bus_master: RTL and testbench
================================

# io_bus_master

Initiator side of the memory-mapped I/O bus (ABUS/DBUS/WE/FLUSH) shared by the processor's peripherals. It accepts single load/store requests from the pipeline's memory stage and drives them onto the bus one transaction at a time. It returns read data to the pipeline. It also services a peripheral's IRQ line in hardware: it reads the device control word, clears its overflow bit by write-back, and presents the captured status to the core with a one-cycle INTR pulse.

## Interface
- BITS, 32, address/data width
- IDLE_ADDR, 32'h0, address driven when no transaction is active; must not match any device
- IRQ_CTL_ADDR, 32'hFFFF_F100, control-register address of the interrupting device
- IRQ_CLR_BIT, 2, control bit cleared by the service write-back
- CLK  in  1  clock; all state changes on posedge
- LOCK  in  1  reset; asynchronous, active-low
- REQ_VALID  in  1  pipeline request present
- REQ_READY  out  1  request accepted this edge when both high
- REQ_WE  in  1  1 = store, 0 = load
- REQ_ADDR  in  BITS  target address
- REQ_WDATA  in  BITS  store data
- KILL  in  1  pipeline flush; cancels the transaction currently on the bus
- RSP_VALID  out  1  one-cycle pulse, load data valid
- RSP_RDATA  out  BITS  load data, held until next load completes
- ABUS  out  BITS  bus address
- DBUS  inout  BITS  bus data; master drives only on write cycles, else high-Z
- WE  out  1  bus write enable
- FLUSH  out  1  bus qualifier; devices ignore the bus while high
- IRQ  in  1  level interrupt from device
- INTR  out  1  one-cycle pulse to core after IRQ service completes
- IRQ_STATUS  out  BITS  control word read during last service, held

## Operation
- States: IDLE, XFER, IRQ_RD, IRQ_WR.
- IDLE: ABUS=IDLE_ADDR, WE=0, DBUS high-Z, FLUSH=1. REQ_READY = !IRQ. Pipeline requests wait while IRQ is high.
- IDLE with IRQ=1 → IRQ_RD. IRQ has priority over a simultaneous REQ_VALID.
- IDLE with REQ_VALID & !IRQ: latch REQ_WE/ADDR/WDATA → XFER.
- XFER (one cycle): ABUS=latched addr, WE=latched we, FLUSH=KILL. DBUS driven with the latched data iff WE. On a load, sample DBUS into RSP_RDATA at the closing edge and pulse RSP_VALID. → IDLE.
- KILL high during XFER: FLUSH=1 that cycle (combinational), no RSP_VALID, RSP_RDATA unchanged. KILL in any other state is ignored.
- IRQ_RD (one cycle): ABUS=IRQ_CTL_ADDR, WE=0, FLUSH=0. Sample DBUS into IRQ_STATUS at the closing edge. → IRQ_WR.
- IRQ_WR (one cycle): ABUS=IRQ_CTL_ADDR, WE=1, FLUSH=0, DBUS = IRQ_STATUS with bit IRQ_CLR_BIT forced to 0 and all other bits as read. Bits written as 1 are retained by the device. → IDLE; INTR pulses in the following IDLE cycle.
- IRQ still high on return to IDLE (device re-fired): service again immediately. No lockout.
- Bus outputs ABUS/WE/DBUS-enable come from registers. FLUSH and REQ_READY are combinational from state plus KILL/IRQ.

## Timing
- Request accepted at edge N → bus cycle N..N+1 → RSP_VALID high in cycle after edge N+1 (load latency 2 edges). Stores complete at edge N+1, with no response.
- Maximum throughput: one transaction per 2 cycles.
- IRQ first seen high in IDLE at edge M → IRQ_RD cycle, IRQ_WR cycle, INTR high in the cycle after edge M+2. Total 3 cycles IRQ-to-INTR.
- Device clears IRQ at the IRQ_WR closing edge, so IRQ is low in the next IDLE unless re-set.
- Reset (LOCK low, any time, including mid-XFER): state=IDLE, ABUS=IDLE_ADDR, WE=0, DBUS high-Z, FLUSH=1, REQ_READY=0 while LOCK low, RSP_VALID=0, RSP_RDATA=0, INTR=0, IRQ_STATUS=0. An aborted transaction produces no response.

## Structure
- Shared package: state encoding (IDLE, XFER, IRQ_RD, IRQ_WR) and timer control-bit index constants (ready bit 0, overflow bit 2), reused by peripheral blocks.
- No sub-module required. Tristate DBUS driver stays inline as a single conditional assign.

## Test plan
- Store 32'hDEAD_BEEF to 32'hFFFF_F004 → ABUS/DBUS/WE=1 for exactly one cycle, FLUSH=0, no RSP_VALID, timer limit register reads back 32'hDEAD_BEEF.
- Load from 32'hFFFF_F000 with timer count=7 → RSP_VALID one cycle, 2 edges after accept, RSP_RDATA=7.
- Timer limit 4, DIV 1, control ready bit set → IRQ rises; IRQ_RD then IRQ_WR with DBUS=32'h1; IRQ falls; INTR pulses; IRQ_STATUS=32'h5.
- IRQ and REQ_VALID rise in the same cycle → REQ_READY=0; service runs first; request accepted in the IDLE cycle after INTR.
- Load issued with KILL high during XFER → FLUSH=1 that cycle, no RSP_VALID, RSP_RDATA unchanged.
- LOCK pulled low during IRQ_RD → all outputs at reset values immediately; after release, IRQ still high → fresh service sequence starts from IRQ_RD.

Source files
------------

// File: rtl/io_bus_master_pkg.sv
// Shared definitions for the I/O bus initiator and the peripherals on that bus:
// the bus-master state encoding and the timer control-word bit positions.
package io_bus_master_pkg;

    // Bus-master sequencing states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_XFER   = 2'd1;
    localparam logic [1:0] ST_IRQ_RD = 2'd2;
    localparam logic [1:0] ST_IRQ_WR = 2'd3;

    // Timer control-word bit positions
    localparam int TMR_READY_BIT = 0;
    localparam int TMR_OVF_BIT   = 2;

endpackage : io_bus_master_pkg

// File: rtl/io_bus_master.sv
// Initiator for the shared memory-mapped I/O bus (ABUS/DBUS/WE/FLUSH).
// It takes single load/store requests from the memory stage and runs one bus
// cycle each. It also services the device IRQ in hardware: it reads the
// control word, writes it back with the overflow bit cleared, and then pulses
// INTR for one cycle. IRQ servicing wins over a pending pipeline request.
module io_bus_master
    import io_bus_master_pkg::*;
#(
    parameter int              BITS         = 32,
    parameter logic [BITS-1:0] IDLE_ADDR    = 32'h0000_0000,
    parameter logic [BITS-1:0] IRQ_CTL_ADDR = 32'hFFFF_F100,
    parameter int              IRQ_CLR_BIT  = TMR_OVF_BIT
) (
    input  logic            CLK,
    input  logic            LOCK,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic            REQ_WE,
    input  logic [BITS-1:0] REQ_ADDR,
    input  logic [BITS-1:0] REQ_WDATA,
    input  logic            KILL,
    output logic            RSP_VALID,
    output logic [BITS-1:0] RSP_RDATA,
    output logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    output logic            WE,
    output logic            FLUSH,
    input  logic            IRQ,
    output logic            INTR,
    output logic [BITS-1:0] IRQ_STATUS
);

    // Control word as written back: the read value with the clear bit forced low
    function automatic logic [BITS-1:0] clearCtlBit(input logic [BITS-1:0] word);
        logic [BITS-1:0] result;
        result              = word;
        result[IRQ_CLR_BIT] = 1'b0;
        return result;
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      stateNext_s;
    logic [BITS-1:0] abus_r;
    logic [BITS-1:0] abusNext_s;
    logic            we_r;
    logic            weNext_s;
    logic            drive_r;
    logic            driveNext_s;
    logic [BITS-1:0] wdata_r;
    logic [BITS-1:0] wdataNext_s;

    logic            rspCapture_s;
    logic            rspValid_r;
    logic [BITS-1:0] rspRdata_r;
    logic            intr_r;
    logic [BITS-1:0] irqStatus_r;

    logic            flush_s;
    logic            reqReady_s;

    // Next state and next bus-register values; bus outputs change only on the edge
    always_comb begin
        stateNext_s = state_r;
        abusNext_s  = abus_r;
        weNext_s    = we_r;
        driveNext_s = drive_r;
        wdataNext_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (IRQ) begin
                    stateNext_s = ST_IRQ_RD;
                    abusNext_s  = IRQ_CTL_ADDR;
                    weNext_s    = 1'b0;
                    driveNext_s = 1'b0;
                end else if (REQ_VALID) begin
                    stateNext_s = ST_XFER;
                    abusNext_s  = REQ_ADDR;
                    weNext_s    = REQ_WE;
                    driveNext_s = REQ_WE;
                    wdataNext_s = REQ_WDATA;
                end else begin
                    stateNext_s = ST_IDLE;
                    abusNext_s  = IDLE_ADDR;
                    weNext_s    = 1'b0;
                    driveNext_s = 1'b0;
                end
            end
            ST_XFER: begin
                stateNext_s = ST_IDLE;
                abusNext_s  = IDLE_ADDR;
                weNext_s    = 1'b0;
                driveNext_s = 1'b0;
            end
            ST_IRQ_RD: begin
                // The write-back word is built from the bus value seen this cycle
                stateNext_s = ST_IRQ_WR;
                abusNext_s  = IRQ_CTL_ADDR;
                weNext_s    = 1'b1;
                driveNext_s = 1'b1;
                wdataNext_s = clearCtlBit(DBUS);
            end
            ST_IRQ_WR: begin
                stateNext_s = ST_IDLE;
                abusNext_s  = IDLE_ADDR;
                weNext_s    = 1'b0;
                driveNext_s = 1'b0;
            end
            default: begin
                stateNext_s = ST_IDLE;
                abusNext_s  = IDLE_ADDR;
                weNext_s    = 1'b0;
                driveNext_s = 1'b0;
            end
        endcase
    end

    // State and bus-driving registers
    always_ff @(posedge CLK or negedge LOCK) begin
        if (!LOCK) begin
            state_r <= ST_IDLE;
            abus_r  <= IDLE_ADDR;
            we_r    <= 1'b0;
            drive_r <= 1'b0;
            wdata_r <= {BITS{1'b0}};
        end else begin
            state_r <= stateNext_s;
            abus_r  <= abusNext_s;
            we_r    <= weNext_s;
            drive_r <= driveNext_s;
            wdata_r <= wdataNext_s;
        end
    end

    // A load completes only if the pipeline did not flush it during its bus cycle
    always_comb begin
        if ((state_r == ST_XFER) && !we_r && !KILL) begin
            rspCapture_s = 1'b1;
        end else begin
            rspCapture_s = 1'b0;
        end
    end

    // Load response: one-cycle valid pulse, data held until the next load lands
    always_ff @(posedge CLK or negedge LOCK) begin
        if (!LOCK) begin
            rspValid_r <= 1'b0;
            rspRdata_r <= {BITS{1'b0}};
        end else begin
            rspValid_r <= rspCapture_s;
            if (rspCapture_s) begin
                rspRdata_r <= DBUS;
            end else begin
                rspRdata_r <= rspRdata_r;
            end
        end
    end

    // IRQ service results: captured control word and the completion pulse
    always_ff @(posedge CLK or negedge LOCK) begin
        if (!LOCK) begin
            intr_r      <= 1'b0;
            irqStatus_r <= {BITS{1'b0}};
        end else begin
            intr_r <= (state_r == ST_IRQ_WR);
            if (state_r == ST_IRQ_RD) begin
                irqStatus_r <= DBUS;
            end else begin
                irqStatus_r <= irqStatus_r;
            end
        end
    end

    // FLUSH and REQ_READY follow state directly so KILL and IRQ act in the same cycle
    always_comb begin
        flush_s    = 1'b1;
        reqReady_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                flush_s    = 1'b1;
                reqReady_s = LOCK && !IRQ;
            end
            ST_XFER: begin
                flush_s    = KILL;
                reqReady_s = 1'b0;
            end
            ST_IRQ_RD: begin
                flush_s    = 1'b0;
                reqReady_s = 1'b0;
            end
            ST_IRQ_WR: begin
                flush_s    = 1'b0;
                reqReady_s = 1'b0;
            end
            default: begin
                flush_s    = 1'b1;
                reqReady_s = 1'b0;
            end
        endcase
    end

    assign DBUS       = drive_r ? wdata_r : {BITS{1'bz}};
    assign ABUS       = abus_r;
    assign WE         = we_r;
    assign FLUSH      = flush_s;
    assign REQ_READY  = reqReady_s;
    assign RSP_VALID  = rspValid_r;
    assign RSP_RDATA  = rspRdata_r;
    assign INTR       = intr_r;
    assign IRQ_STATUS = irqStatus_r;

endmodule : io_bus_master

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: a timer peripheral model on the bus, a cycle
// planner model of the master, a per-cycle compare process and directed tests.
module tb_io_bus_master;
    import io_bus_master_pkg::*;

    localparam logic [31:0] IDLE_A = 32'h0000_0000;
    localparam logic [31:0] CNT_A  = 32'hFFFF_F000;
    localparam logic [31:0] LIM_A  = 32'hFFFF_F004;
    localparam logic [31:0] DIV_A  = 32'hFFFF_F008;
    localparam logic [31:0] CTL_A  = 32'hFFFF_F100;
    localparam int          CLR_BIT = 2;

    localparam logic [1:0] K_USER = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_WR   = 2'd2;

    logic        CLK = 1'b0;
    logic        LOCK = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_WE = 1'b0;
    logic [31:0] REQ_ADDR = 32'h0;
    logic [31:0] REQ_WDATA = 32'h0;
    logic        KILL = 1'b0;
    wire         REQ_READY;
    wire         RSP_VALID;
    wire  [31:0] RSP_RDATA;
    wire  [31:0] ABUS;
    wire  [31:0] DBUS;
    wire         WE;
    wire         FLUSH;
    wire         IRQ;
    wire         INTR;
    wire  [31:0] IRQ_STATUS;

    int nTests = 0;
    int nFail  = 0;
    logic checkEn = 1'b0;

    io_bus_master dut (
        .CLK(CLK), .LOCK(LOCK),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .KILL(KILL),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
        .ABUS(ABUS), .DBUS(DBUS), .WE(WE), .FLUSH(FLUSH),
        .IRQ(IRQ), .INTR(INTR), .IRQ_STATUS(IRQ_STATUS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timer peripheral model ----------------
    logic [31:0] devCnt = 32'h0, devLim = 32'h0, devDiv = 32'h1, devCtl = 32'h0, devPresc = 32'h0;
    logic        bdSetOvf = 1'b0;

    function automatic logic devMapped(input logic [31:0] a);
        return (a == CNT_A) || (a == LIM_A) || (a == DIV_A) || (a == CTL_A);
    endfunction

    function automatic logic [31:0] devRead(input logic [31:0] a);
        case (a)
            CNT_A:   return devCnt;
            LIM_A:   return devLim;
            DIV_A:   return devDiv;
            CTL_A:   return devCtl;
            default: return 32'h0;
        endcase
    endfunction

    assign DBUS = (!FLUSH && !WE && devMapped(ABUS)) ? devRead(ABUS) : 32'hzzzz_zzzz;
    assign IRQ  = devCtl[TMR_OVF_BIT];

    // Timer counting and bus writes; a bus write overrides the timer's own update
    always @(posedge CLK) begin
        if (devCtl[TMR_READY_BIT]) begin
            if (devPresc + 32'd1 >= devDiv) begin
                devPresc <= 32'h0;
                if (devCnt + 32'd1 == devLim) begin
                    devCnt <= 32'h0;
                    devCtl[TMR_OVF_BIT] <= 1'b1;
                end else begin
                    devCnt <= devCnt + 32'd1;
                end
            end else begin
                devPresc <= devPresc + 32'd1;
            end
        end
        if (bdSetOvf) devCtl[TMR_OVF_BIT] <= 1'b1;
        if (!FLUSH && WE) begin
            case (ABUS)
                CNT_A:   devCnt <= DBUS;
                LIM_A:   devLim <= DBUS;
                DIV_A:   devDiv <= DBUS;
                CTL_A:   devCtl <= DBUS;
                default: ;
            endcase
        end
    end

    // ---------------- master model: a plan of upcoming bus cycles ----------------
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } cyc_t;

    cyc_t        plan[$];
    cyc_t        mCur;
    logic        mRspValid = 1'b0;
    logic        mIntr = 1'b0;
    logic [31:0] mRdata = 32'h0;
    logic [31:0] mStatus = 32'h0;

    initial forever begin
        @(posedge CLK or negedge LOCK);
        if (!LOCK) begin
            plan.delete();
            mRspValid = 1'b0; mIntr = 1'b0; mRdata = 32'h0; mStatus = 32'h0;
        end else begin
            mRspValid = 1'b0; mIntr = 1'b0;
            if (plan.size() == 0) begin
                if (IRQ)            plan.push_back('{K_RD, CTL_A, 1'b0, 32'h0});
                else if (REQ_VALID) plan.push_back('{K_USER, REQ_ADDR, REQ_WE, REQ_WDATA});
            end else begin
                mCur = plan.pop_front();
                if (mCur.kind == K_USER && !mCur.we && !KILL) begin
                    mRspValid = 1'b1;
                    mRdata    = devRead(mCur.addr);
                end
                if (mCur.kind == K_RD) begin
                    mStatus = devRead(CTL_A);
                    plan.push_back('{K_WR, CTL_A, 1'b1, devRead(CTL_A) & ~(32'h1 << CLR_BIT)});
                end
                if (mCur.kind == K_WR) mIntr = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [31:0] eAbus;
        logic        eWe, eFlush, eReady;
        cyc_t        c;
        @(negedge CLK);
        if (checkEn) begin
            if (plan.size() == 0) begin
                eAbus = IDLE_A; eWe = 1'b0; eFlush = 1'b1; eReady = LOCK && !IRQ;
                c = '{K_USER, IDLE_A, 1'b0, 32'h0};
            end else begin
                c = plan[0];
                eAbus = c.addr; eWe = c.we; eReady = 1'b0;
                eFlush = (c.kind == K_USER) ? KILL : 1'b0;
            end
            chk("cyc ABUS", ABUS, eAbus);
            chk("cyc WE", 32'(WE), 32'(eWe));
            chk("cyc FLUSH", 32'(FLUSH), 32'(eFlush));
            chk("cyc REQ_READY", 32'(REQ_READY), 32'(eReady));
            chk("cyc RSP_VALID", 32'(RSP_VALID), 32'(mRspValid));
            chk("cyc RSP_RDATA", RSP_RDATA, mRdata);
            chk("cyc INTR", 32'(INTR), 32'(mIntr));
            chk("cyc IRQ_STATUS", IRQ_STATUS, mStatus);
            if (eWe) chk("cyc DBUS", DBUS, c.data);
        end
    end

    // ---------------- directed stimulus ----------------
    // Issue one request starting at a negedge; returns after the cycle following the bus cycle
    task automatic doReq(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input string tag, output logic [31:0] rdata);
        int waited = 0;
        REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wd;
        while (!REQ_READY && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        chk({tag, " accept in budget"}, 32'(REQ_READY), 32'h1);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        chk({tag, " bus ABUS"}, ABUS, addr);
        chk({tag, " bus WE"}, 32'(WE), 32'(we));
        chk({tag, " bus FLUSH"}, 32'(FLUSH), 32'h0);
        chk({tag, " no early RSP"}, 32'(RSP_VALID), 32'h0);
        if (we) chk({tag, " bus DBUS"}, DBUS, wd);
        @(negedge CLK);
        chk({tag, " WE one cycle"}, 32'(WE), 32'h0);
        chk({tag, " RSP_VALID"}, 32'(RSP_VALID), 32'(!we));
        rdata = RSP_RDATA;
    endtask

    logic [31:0] rd;
    int          waited;
    logic [31:0] btbAddr [3] = '{LIM_A, DIV_A, LIM_A};
    logic [31:0] btbData [3] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};

    initial begin
        // Reset
        repeat (3) @(negedge CLK);
        checkEn = 1'b1;
        chk("rst ABUS", ABUS, 32'h0);
        chk("rst WE", 32'(WE), 32'h0);
        chk("rst FLUSH", 32'(FLUSH), 32'h1);
        chk("rst REQ_READY", 32'(REQ_READY), 32'h0);
        chk("rst RSP_VALID", 32'(RSP_VALID), 32'h0);
        chk("rst RSP_RDATA", RSP_RDATA, 32'h0);
        chk("rst INTR", 32'(INTR), 32'h0);
        chk("rst IRQ_STATUS", IRQ_STATUS, 32'h0);
        #2 LOCK = 1'b1;
        @(negedge CLK);
        chk("ready after reset", 32'(REQ_READY), 32'h1);

        // Store to the limit register, then read it back
        doReq(1'b1, LIM_A, 32'hDEAD_BEEF, "st lim", rd);
        chk("dev limit written", devLim, 32'hDEAD_BEEF);
        doReq(1'b0, LIM_A, 32'h0, "ld lim", rd);
        chk("ld lim data", rd, 32'hDEAD_BEEF);

        // Count register holding 7, load it
        doReq(1'b1, CNT_A, 32'd7, "st cnt", rd);
        doReq(1'b0, CNT_A, 32'h0, "ld cnt", rd);
        chk("ld cnt data", rd, 32'd7);

        // Timer overflow drives a full IRQ service
        doReq(1'b1, CNT_A, 32'd0, "st cnt0", rd);
        doReq(1'b1, LIM_A, 32'd4, "st lim4", rd);
        doReq(1'b1, DIV_A, 32'd1, "st div1", rd);
        doReq(1'b1, CTL_A, 32'h1, "st ctl1", rd);
        waited = 0;
        while (!IRQ && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        chk("irq rises", 32'(IRQ), 32'h1);
        @(negedge CLK);
        chk("irq rd ABUS", ABUS, CTL_A);
        chk("irq rd WE", 32'(WE), 32'h0);
        @(negedge CLK);
        chk("irq wr ABUS", ABUS, CTL_A);
        chk("irq wr WE", 32'(WE), 32'h1);
        chk("irq wr DBUS", DBUS, 32'h0000_0001);
        @(negedge CLK);
        chk("irq INTR pulse", 32'(INTR), 32'h1);
        chk("irq cleared", 32'(IRQ), 32'h0);
        chk("irq status", IRQ_STATUS, 32'h0000_0005);
        @(negedge CLK);
        chk("irq INTR one cycle", 32'(INTR), 32'h0);
        doReq(1'b1, CTL_A, 32'h0, "st ctl0", rd);
        @(negedge CLK);
        chk("timer stopped", 32'(IRQ), 32'h0);

        // IRQ and a request arrive together: service first, then accept
        bdSetOvf = 1'b1;
        @(posedge CLK); #1;
        bdSetOvf = 1'b0;
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = LIM_A; REQ_WDATA = 32'h1234_5678;
        @(negedge CLK);
        chk("simul IRQ high", 32'(IRQ), 32'h1);
        chk("simul not ready", 32'(REQ_READY), 32'h0);
        waited = 0;
        while (!REQ_READY && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        chk("simul wait cycles", 32'(waited), 32'd3);
        chk("simul INTR at accept", 32'(INTR), 32'h1);
        chk("simul status", IRQ_STATUS, 32'h0000_0004);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("simul bus ABUS", ABUS, LIM_A);
        chk("simul bus DBUS", DBUS, 32'h1234_5678);
        @(negedge CLK);
        chk("simul dev limit", devLim, 32'h1234_5678);

        // Killed load
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = CNT_A;
        waited = 0;
        while (!REQ_READY && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0; KILL = 1'b1;
        @(negedge CLK);
        chk("kill FLUSH", 32'(FLUSH), 32'h1);
        chk("kill ABUS", ABUS, CNT_A);
        @(posedge CLK); #1;
        KILL = 1'b0;
        @(negedge CLK);
        chk("kill no RSP", 32'(RSP_VALID), 32'h0);
        chk("kill RDATA held", RSP_RDATA, 32'd7);
        doReq(1'b0, LIM_A, 32'h0, "ld after kill", rd);
        chk("ld after kill data", rd, 32'h1234_5678);

        // Reset in the middle of IRQ_RD, then a fresh service
        bdSetOvf = 1'b1;
        @(posedge CLK); #1;
        bdSetOvf = 1'b0;
        waited = 0;
        do begin
            @(negedge CLK);
            waited++;
        end while (!(ABUS == CTL_A && !WE) && waited < 10);
        chk("reached IRQ_RD", ABUS, CTL_A);
        #2 LOCK = 1'b0;
        #1;
        chk("lock ABUS", ABUS, 32'h0);
        chk("lock WE", 32'(WE), 32'h0);
        chk("lock FLUSH", 32'(FLUSH), 32'h1);
        chk("lock REQ_READY", 32'(REQ_READY), 32'h0);
        chk("lock RSP_VALID", 32'(RSP_VALID), 32'h0);
        chk("lock RSP_RDATA", RSP_RDATA, 32'h0);
        chk("lock INTR", 32'(INTR), 32'h0);
        chk("lock IRQ_STATUS", IRQ_STATUS, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        #2 LOCK = 1'b1;
        chk("irq held over reset", 32'(IRQ), 32'h1);
        @(negedge CLK);
        chk("reserv rd ABUS", ABUS, CTL_A);
        chk("reserv rd WE", 32'(WE), 32'h0);
        @(negedge CLK);
        chk("reserv wr DBUS", DBUS, 32'h0);
        @(negedge CLK);
        chk("reserv INTR", 32'(INTR), 32'h1);
        chk("reserv status", IRQ_STATUS, 32'h0000_0004);

        // Back-to-back stores with REQ_VALID held high
        REQ_VALID = 1'b1; REQ_WE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            REQ_ADDR = btbAddr[i]; REQ_WDATA = btbData[i];
            waited = 0;
            while (!REQ_READY && waited < 20) begin
                @(negedge CLK);
                waited++;
            end
            chk("btb accept", 32'(REQ_READY), 32'h1);
            @(posedge CLK); #1;
        end
        REQ_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        doReq(1'b0, LIM_A, 32'h0, "btb ld lim", rd);
        chk("btb lim data", rd, 32'h0000_0033);
        doReq(1'b0, DIV_A, 32'h0, "btb ld div", rd);
        chk("btb div data", rd, 32'h0000_0022);

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_io_bus_master
